// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : write-back stage of the NPC core.
//
// Accepts one completed instruction at a time from the execute/memory side.
// Non-loads are written back on the cycle after the handshake. Loads wait for
// the memory response, then the byte/halfword/word is extracted, extended and
// written back on the cycle after mem_rvalid. The register-file write port and
// the in-flight destination (for RAW-hazard stalls in decode) are decoded from
// registered state only; nothing from in_* reaches rf_* combinationally.
//
// Optional feature macro: WB_COMMIT_TRACE_EN
//   When defined, adds in_pc (captured on handshake), commit_valid (high in
//   every write-back cycle, even for x0 / no-write instructions) and commit_pc
//   for difftest and the ebreak/trap monitor.
//
// Parameters
//   ADDR_WIDTH  register index width (must match the register file)
//   DATA_WIDTH  datapath width; only 32 is meaningful (RV32 load extraction)
//
// Ports
//   clk          in   clock
//   rst          in   synchronous reset, active-low
//   in_valid     in   upstream presents a completed instruction
//   in_ready     out  stage can accept an instruction (depends on state only)
//   in_rd        in   destination register
//   in_rd_wen    in   instruction writes rd
//   in_is_load   in   result comes from memory instead of in_result
//   in_funct3    in   load type
//   in_addr_lo   in   low two bits of the load address
//   in_result    in   ALU/CSR/link result for non-loads
//   mem_rvalid   in   load data valid (single-cycle pulse)
//   mem_rdata    in   raw aligned 32-bit memory word
//   rf_wen       out  register-file write enable (never for x0)
//   rf_waddr     out  register-file write address
//   rf_wdata     out  register-file write data
//   busy_valid   out  a write to busy_rd is still pending
//   busy_rd      out  pending destination register
//   in_pc        in   (WB_COMMIT_TRACE_EN) pc of the incoming instruction
//   commit_valid out  (WB_COMMIT_TRACE_EN) instruction retires this cycle
//   commit_pc    out  (WB_COMMIT_TRACE_EN) pc of the retiring instruction
// -----------------------------------------------------------------------------
module wb_stage #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef WB_COMMIT_TRACE_EN
   input  logic [31:0]           in_pc,
   output logic                  commit_valid,
   output logic [31:0]           commit_pc,
`endif
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_rd_wen,
   input  logic                  in_is_load,
   input  logic [2:0]            in_funct3,
   input  logic [1:0]            in_addr_lo,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  busy_valid,
   output logic [ADDR_WIDTH-1:0] busy_rd
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   rd_p1;
   logic                    rd_wen_p1;
   logic [2:0]              funct3_p1;
   logic [1:0]              addr_lo_p1;
   logic [DATA_WIDTH-1:0]   data_p1;
`ifdef WB_COMMIT_TRACE_EN
   logic [31:0]             pc_p1;
`endif

   logic                    accept;
   logic                    rd_live;

   // Select the addressed byte/halfword of the memory word and extend it.
   // Unknown funct3 encodings fall back to the full word.
   function automatic logic [DATA_WIDTH-1:0] load_extract(
      input logic [DATA_WIDTH-1:0] word,
      input logic [2:0]            f3,
      input logic [1:0]            lo
   );
      logic signed [7:0]     b;
      logic signed [15:0]    h;
      logic [DATA_WIDTH-1:0] r;
      case (lo)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         3'd0:    r = DATA_WIDTH'(b);              // LB  : sign-extend
         3'd4:    r = DATA_WIDTH'(unsigned'(b));   // LBU : zero-extend
         3'd1:    r = DATA_WIDTH'(h);              // LH  : sign-extend
         3'd5:    r = DATA_WIDTH'(unsigned'(h));   // LHU : zero-extend
         default: r = word;                        // LW and reserved encodings
      endcase
      return r;
   endfunction

   // WRITE can take the next instruction, so back-to-back non-loads retire
   // one per cycle; only an outstanding load blocks upstream.
   assign in_ready = (state != WAIT_MEM);
   assign accept   = in_valid && in_ready;
   assign rd_live  = rd_wen_p1 && (rd_p1 != '0);

   // Capture stage: instruction fields, load completion and state sequencing
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         rd_p1      <= '0;
         rd_wen_p1  <= 1'b0;
         funct3_p1  <= '0;
         addr_lo_p1 <= '0;
         data_p1    <= '0;
`ifdef WB_COMMIT_TRACE_EN
         pc_p1      <= '0;
`endif
      end else begin
         case (state)
            IDLE, WRITE: begin
               if (accept) begin
                  rd_p1      <= in_rd;
                  rd_wen_p1  <= in_rd_wen;
                  funct3_p1  <= in_funct3;
                  addr_lo_p1 <= in_addr_lo;
`ifdef WB_COMMIT_TRACE_EN
                  pc_p1      <= in_pc;
`endif
                  if (in_is_load) begin
                     // mem_rvalid in this same cycle belongs to no one yet
                     state <= WAIT_MEM;
                  end else begin
                     data_p1 <= in_result;
                     state   <= WRITE;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_MEM: begin
               if (mem_rvalid) begin
                  data_p1 <= load_extract(mem_rdata, funct3_p1, addr_lo_p1);
                  state   <= WRITE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write-back stage: register-file port and hazard report from held state
   assign rf_wen     = (state == WRITE) && rd_live;
   assign rf_waddr   = rd_p1;
   assign rf_wdata   = data_p1;
   assign busy_valid = ((state == WAIT_MEM) || (state == WRITE)) && rd_live;
   assign busy_rd    = rd_p1;

`ifdef WB_COMMIT_TRACE_EN
   assign commit_valid = (state == WRITE);
   assign commit_pc    = pc_p1;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_result;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        busy_valid;
   logic [4:0]  busy_rd;
`ifdef WB_COMMIT_TRACE_EN
   logic [31:0] in_pc;
   logic        commit_valid;
   logic [31:0] commit_pc;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef WB_COMMIT_TRACE_EN
      .in_pc       (in_pc),
      .commit_valid(commit_valid),
      .commit_pc   (commit_pc),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_rd_wen  (in_rd_wen),
      .in_is_load (in_is_load),
      .in_funct3  (in_funct3),
      .in_addr_lo (in_addr_lo),
      .in_result  (in_result),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .busy_valid (busy_valid),
      .busy_rd    (busy_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        is_load;
      logic [4:0]  rd;
      logic        rd_wen;
      logic [2:0]  funct3;
      logic [1:0]  addr_lo;
      logic [31:0] result;
      logic [31:0] word;
      int          gap;
      logic        exp_wen;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference load extraction straight from the ISA rules, plain arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] lo);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * lo)) & 32'hFF;
      h = (w >> (16 * lo[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   task automatic idle_inputs();
      in_valid   = 1'b0;
      in_rd      = 5'($urandom);
      in_rd_wen  = 1'($urandom);
      in_is_load = 1'($urandom);
      in_funct3  = 3'($urandom);
      in_addr_lo = 2'($urandom);
      in_result  = $urandom;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
`ifdef WB_COMMIT_TRACE_EN
      in_pc      = $urandom;
`endif
   endtask

   // Entry/exit point: #1 after a rising edge, DUT idle.
   task automatic run_vec(input vec_t v, input logic [31:0] pc);
      in_valid   = 1'b1;
      in_is_load = v.is_load;
      in_rd      = v.rd;
      in_rd_wen  = v.rd_wen;
      in_funct3  = v.funct3;
      in_addr_lo = v.addr_lo;
      in_result  = v.result;
      mem_rvalid = 1'b0;
`ifdef WB_COMMIT_TRACE_EN
      in_pc      = pc;
`endif
      @(negedge clk);
      chk("ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      if (v.is_load) begin
         for (int i = 0; i <= v.gap; i++) begin
            // upstream keeps offering while blocked; nothing may be taken
            in_valid = 1'($urandom);
            @(negedge clk);
            chk("ready_wait", 32'(in_ready), 32'd0);
            chk("wen_wait", 32'(rf_wen), 32'd0);
            chk("busy_wait", 32'(busy_valid), 32'(v.exp_wen));
            @(posedge clk); #1;
            if (i == v.gap) begin
               in_valid   = 1'b0;
               mem_rvalid = 1'b1;
               mem_rdata  = v.word;
            end
         end
         @(posedge clk); #1;
         idle_inputs();
      end
      @(negedge clk);
      chk("rf_wen", 32'(rf_wen), 32'(v.exp_wen));
      chk("rf_waddr", 32'(rf_waddr), 32'(v.rd));
      chk("rf_wdata", rf_wdata, v.exp_data);
      chk("busy_valid", 32'(busy_valid), 32'(v.exp_wen));
      chk("busy_rd", 32'(busy_rd), 32'(v.rd));
`ifdef WB_COMMIT_TRACE_EN
      chk("commit_valid", 32'(commit_valid), 32'd1);
      chk("commit_pc", commit_pc, pc);
`endif
      @(posedge clk); #1;
      @(negedge clk);
      chk("wen_after", 32'(rf_wen), 32'd0);
      chk("busy_after", 32'(busy_valid), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t       v;
      logic [4:0] b2b_rd[4];
      logic [31:0] b2b_d[4];

      //            ld  rd  wen f3 lo result        word          gap ewen edata
      vecs[0]  = '{0, 5,  1, 0, 0, 32'h12345678, 32'h0,        0, 1, 32'h12345678};
      vecs[1]  = '{1, 10, 1, 0, 3, 32'h0,        32'h80FF0011, 3, 1, 32'hFFFFFF80};
      vecs[2]  = '{1, 11, 1, 5, 2, 32'h0,        32'h80017FFF, 1, 1, 32'h00008001};
      vecs[3]  = '{0, 0,  1, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF};
      vecs[4]  = '{1, 12, 1, 4, 1, 32'h0,        32'h1234F600, 0, 1, 32'h000000F6};
      vecs[5]  = '{1, 13, 1, 1, 0, 32'h0,        32'h12348765, 2, 1, 32'hFFFF8765};
      vecs[6]  = '{1, 14, 1, 2, 0, 32'h0,        32'hA5A55A5A, 0, 1, 32'hA5A55A5A};
      vecs[7]  = '{1, 15, 1, 3, 1, 32'h0,        32'h0BADF00D, 1, 1, 32'h0BADF00D};
      vecs[8]  = '{0, 7,  0, 0, 0, 32'h00000055, 32'h0,        0, 0, 32'h00000055};
      vecs[9]  = '{1, 16, 1, 0, 1, 32'h0,        32'h00007F00, 0, 1, 32'h0000007F};
      vecs[10] = '{1, 31, 1, 1, 2, 32'h0,        32'h7FFF8000, 2, 1, 32'h00007FFF};

      idle_inputs();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // first cycle after reset
      @(negedge clk);
      chk("rst_wen", 32'(rf_wen), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_busy", 32'(busy_valid), 32'd0);
      chk("rst_busy_rd", 32'(busy_rd), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef WB_COMMIT_TRACE_EN
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("rst_commit_pc", commit_pc, 32'd0);
`endif
      @(posedge clk); #1;

      foreach (vecs[i]) run_vec(vecs[i], 32'h8000_0000 + 32'(i) * 4);

      // four back-to-back non-loads, in_valid held high
      for (int k = 0; k < 4; k++) begin
         b2b_rd[k] = 5'(k + 1);
         b2b_d[k]  = 32'hC0DE_0000 + 32'(k);
      end
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            in_valid   = 1'b1;
            in_is_load = 1'b0;
            in_rd      = b2b_rd[k];
            in_rd_wen  = 1'b1;
            in_result  = b2b_d[k];
         end else begin
            idle_inputs();
         end
         @(negedge clk);
         if (k < 4) chk("b2b_ready", 32'(in_ready), 32'd1);
         if (k > 0) begin
            chk("b2b_wen", 32'(rf_wen), 32'd1);
            chk("b2b_waddr", 32'(rf_waddr), 32'(b2b_rd[k-1]));
            chk("b2b_wdata", rf_wdata, b2b_d[k-1]);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("b2b_end_wen", 32'(rf_wen), 32'd0);
      @(posedge clk); #1;

      // mem_rvalid coinciding with the load handshake must be ignored
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_rd      = 5'd20;
      in_rd_wen  = 1'b1;
      in_funct3  = 3'd2;
      in_addr_lo = 2'd0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("early_rvalid_ready", 32'(in_ready), 32'd0);
      chk("early_rvalid_wen", 32'(rf_wen), 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h600DF00D;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("late_rvalid_wen", 32'(rf_wen), 32'd1);
      chk("late_rvalid_data", rf_wdata, 32'h600DF00D);
      @(posedge clk); #1;

      // reset while a load is outstanding
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_rd      = 5'd9;
      in_rd_wen  = 1'b1;
      in_funct3  = 3'd2;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("midload_ready", 32'(in_ready), 32'd0);
      chk("midload_busy", 32'(busy_valid), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h11112222;
      @(negedge clk);
      chk("midload_rst_ready", 32'(in_ready), 32'd1);
      chk("midload_rst_busy", 32'(busy_valid), 32'd0);
      chk("midload_rst_wen", 32'(rf_wen), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("midload_late_wen", 32'(rf_wen), 32'd0);
      chk("midload_late_ready", 32'(in_ready), 32'd1);
      chk("midload_late_busy", 32'(busy_valid), 32'd0);
      @(posedge clk); #1;

      // randomized transactions against the reference model
      for (int n = 0; n < 300; n++) begin
         v.is_load  = 1'($urandom);
         v.rd       = 5'($urandom);
         v.rd_wen   = ($urandom_range(0, 3) != 0);
         v.funct3   = 3'($urandom);
         v.addr_lo  = 2'($urandom);
         v.result   = $urandom;
         v.word     = $urandom;
         v.gap      = $urandom_range(0, 3);
         v.exp_wen  = v.rd_wen && (v.rd != 5'd0);
         v.exp_data = v.is_load ? ref_load(v.word, v.funct3, v.addr_lo) : v.result;
         repeat ($urandom_range(0, 2)) begin
            mem_rvalid = 1'($urandom);   // stray responses while idle
            @(negedge clk);
            chk("rand_idle_wen", 32'(rf_wen), 32'd0);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
         end
         run_vec(v, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
